shift_accumulator: RTL and testbench

- Bit-serial shift-and-accumulate stage. It sits directly downstream of the adder tree, whose final `add` stage produces a width+1-bit sum.
- Each macro compute cycle presents one input-activation bit-plane. The adder tree delivers one partial sum per bit-plane, LSB plane first.
- This block weights each partial sum by 2^bit_index and accumulates the result. It subtracts the MSB-plane term when operating in two's-complement mode (sus=1).
- It emits one full-precision dot-product result per operation over a valid/ready output handshake.

---
 rtl/dcim_pkg.sv | 32 +++
 rtl/shift_accumulator.sv | 107 ++++++++++
 tb/tb_shift_accumulator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM datapath: default widths, the shift-accumulator
// state type and a width-generic sign/zero-extension helper.
package dcim_pkg;

    localparam int unsigned IN_W_DEF    = 13;
    localparam int unsigned IN_BITS_DEF = 8;

    // Extension works on a fixed wide container so callers of any width can share it.
    localparam int unsigned EXT_W  = 64;
    localparam int unsigned EXT_IW = 6;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Extends the low `width` bits of data to EXT_W bits; callers truncate to their own width.
    function automatic logic [EXT_W-1:0] ext(
        input logic [EXT_W-1:0] data,
        input int unsigned      width,
        input logic             signed_mode
    );
        logic [EXT_W-1:0] r;
        logic             fill;
        fill = signed_mode & data[EXT_IW'(width - 1)];
        for (int unsigned i = 0; i < EXT_W; i++) begin
            r[EXT_IW'(i)] = (i < width) ? data[EXT_IW'(i)] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_accumulator.sv
// Bit-serial shift-and-accumulate stage: weights each bit-plane partial sum by
// 2^plane and accumulates, subtracting the MSB-plane term in two's-complement mode.
module shift_accumulator
    import dcim_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned IN_BITS = IN_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    sus,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IN_W+IN_BITS-1:0] out_data,
    output logic                    busy
);

    localparam int unsigned ACC_W = IN_W + IN_BITS;
    localparam int unsigned CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sus_q, sus_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;

    logic               first_beat;
    logic               last_beat;
    logic               eff_sus;
    logic [ACC_W-1:0]   ext_data;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum;

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == CNT_W'(IN_BITS - 1));
    assign eff_sus    = first_beat ? sus : sus_q;
    assign ext_data   = ACC_W'(ext(EXT_W'(in_data), IN_W, eff_sus));
    assign term       = ext_data << cnt_q;
    // Beat 0 starts from zero so any stale accumulator contents are discarded.
    assign base       = first_beat ? '0 : acc_q;
    assign sum        = (last_beat && eff_sus) ? (base - term) : (base + term);

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sus_d      = sus_q;
        out_data_d = out_data_q;
        if (clr) begin
            state_d = ACC;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (in_valid) begin
                        if (first_beat) begin
                            sus_d = sus;
                        end
                        acc_d = sum;
                        if (last_beat) begin
                            out_data_d = sum;
                            cnt_d      = '0;
                            state_d    = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            sus_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sus_q      <= sus_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_shift_accumulator.sv
// Self-checking bench for shift_accumulator: directed corner cases plus randomized
// operations compared against an integer reference model.
module tb_shift_accumulator;

    localparam int unsigned IN_W    = 13;
    localparam int unsigned IN_BITS = 8;
    localparam int unsigned ACC_W   = IN_W + IN_BITS;

    typedef logic [IN_W-1:0] plane_t [IN_BITS];

    logic               clk;
    logic               rst;
    logic               clr;
    logic               sus;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic               busy;

    int n_cmp;
    int n_err;

    shift_accumulator #(
        .IN_W    (IN_W),
        .IN_BITS (IN_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sus       (sus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Dot product of the bit-planes: sum of v_i * 2^i, MSB plane negated in signed mode.
    function automatic logic [ACC_W-1:0] model(input plane_t d, input logic s);
        longint total;
        longint v;
        total = 0;
        for (int i = 0; i < IN_BITS; i++) begin
            v = s ? longint'($signed(d[i])) : longint'(d[i]);
            if (s && i == IN_BITS - 1) total -= v * (longint'(1) << i);
            else                       total += v * (longint'(1) << i);
        end
        return ACC_W'(total);
    endfunction

    task automatic beat(input logic [IN_W-1:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        sus      = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic fill(output plane_t d, input logic [IN_W-1:0] v);
        for (int i = 0; i < IN_BITS; i++) d[i] = v;
    endtask

    task automatic do_op(input plane_t d, input logic s0, input logic s_later,
                         input bit gaps, input int hold, input logic [ACC_W-1:0] exp,
                         input string tag);
        int idle;
        out_ready = (hold == 0);
        for (int i = 0; i < IN_BITS; i++) begin
            if (gaps && i > 0) begin
                idle = $urandom_range(0, 2);
                repeat (idle) begin
                    @(posedge clk);
                    #1;
                end
            end
            beat(d[i], (i == 0) ? s0 : s_later);
            if (i == IN_BITS / 2) begin
                @(negedge clk);
                check({tag, "_busy_mid"}, 64'(busy), 64'd1);
                check({tag, "_noval_mid"}, 64'(out_valid), 64'd0);
            end
        end
        // Offered beats during HOLD must be ignored, including the handshake cycle.
        in_valid = 1'b1;
        in_data  = IN_W'($urandom);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_rdy_hold"}, 64'(in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            in_data = IN_W'($urandom);
            @(negedge clk);
            check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_bp_data"}, 64'(out_data), 64'(exp));
            check({tag, "_bp_rdy"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
        check({tag, "_no_consume"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        plane_t d;
        logic   s0, s1;
        int     hold;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        sus       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        fill(d, 13'd1);
        do_op(d, 1'b0, 1'b0, 1'b0, 0, 21'd255, "t1_ones_u");
        do_op(d, 1'b1, 1'b1, 1'b0, 0, 21'h1FFFFF, "t2_ones_s");
        fill(d, 13'd0); d[0] = 13'h1FF6;
        do_op(d, 1'b1, 1'b1, 1'b0, 0, 21'h1FFFF6, "t2_neg_b0");
        fill(d, 13'd0); d[IN_BITS-1] = 13'h1FF6;
        do_op(d, 1'b1, 1'b1, 1'b0, 0, 21'd1280, "t2_neg_b7");
        fill(d, 13'h1FFF);
        do_op(d, 1'b0, 1'b0, 1'b0, 0, 21'd2088705, "t3_max_u");
        fill(d, 13'd0); d[IN_BITS-1] = 13'h1000;
        do_op(d, 1'b1, 1'b1, 1'b0, 0, 21'd524288, "t3_ext_s");
        fill(d, 13'd1);
        do_op(d, 1'b0, 1'b0, 1'b0, 5, 21'd255, "t4_backpr");
        do_op(d, 1'b0, 1'b1, 1'b0, 0, 21'd255, "t5_sus_tog");

        // Abort with synchronous clear; the beat offered alongside clr is dropped.
        repeat (3) beat(13'd5, 1'b0);
        in_valid = 1'b1; in_data = 13'd5; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t6_clr_busy", 64'(busy), 64'd0);
        check("t6_clr_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        do_op(d, 1'b0, 1'b0, 1'b0, 0, 21'd255, "t6_after_clr");

        // Abort with asynchronous reset in the middle of a cycle.
        repeat (3) beat(13'd5, 1'b0);
        in_valid = 1'b1; in_data = 13'd5;
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_data", 64'(out_data), 64'd0);
        check("t6_arst_valid", 64'(out_valid), 64'd0);
        check("t6_arst_busy", 64'(busy), 64'd0);
        check("t6_arst_ready", 64'(in_ready), 64'd1);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_op(d, 1'b0, 1'b0, 1'b0, 0, 21'd255, "t6_after_rst");

        // Clear while holding a result: result dropped but out_data retained.
        fill(d, 13'd2);
        out_ready = 1'b0;
        for (int i = 0; i < IN_BITS; i++) beat(d[i], 1'b0);
        @(negedge clk);
        check("clrh_valid", 64'(out_valid), 64'd1);
        check("clrh_data", 64'(out_data), 64'd510);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("clrh_drop", 64'(out_valid), 64'd0);
        check("clrh_keep", 64'(out_data), 64'd510);
        check("clrh_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < IN_BITS; i++) d[i] = IN_W'($urandom);
            s0   = 1'($urandom);
            s1   = 1'($urandom);
            hold = $urandom_range(0, 3);
            do_op(d, s0, s1, 1'b1, hold, model(d, s0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
